onehot_alu_sequencer: RTL and testbench

Sequential front end for the one-hot ALU datapath. It collects two one-hot operands from a keypad/switch interface using a valid/ready handshake, then accepts an opcode. It drives the combinational one-hot ALU top level (inp1/inp2/Opc), waits a programmable settle time, then captures the one-hot result and overflow into registered outputs. The result is held until acknowledged. Sits directly upstream of the one-hot ALU top and consumes its outputs.

---
 rtl/onehot_alu_sequencer.sv | 169 ++++++++++++++++
 tb/tb_onehot_alu_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/onehot_alu_sequencer.sv
// rtl/onehot_alu_sequencer.sv - valid/ready operand/opcode sequencer in front of the one-hot ALU
//
// Collects two one-hot operands over a key handshake, accepts an opcode,
// holds the ALU inputs for SETTLE_CYCLES, then captures and holds the ALU
// result until it is acknowledged.
//
// Optional feature macro: CHAIN_OPERAND_EN (running-total chaining from DONE).
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   key_valid, key_onehot    operand offer (one-hot 16-bit)
//   key_ready                operand accepted when key_valid && key_ready
//   start, opc_in            launch request with opcode (WAIT_OP only)
//   alu_inp1/2, alu_opc      registered drive to the one-hot ALU
//   alu_out, alu_ovf         combinational ALU result
//   res_onehot, res_ovf      captured result
//   res_valid, res_ack       result hold / consumer acknowledge
//   busy                     any state except LOAD_A
//   err                      one-cycle pulse on a rejected input
module onehot_alu_sequencer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    input  logic [15:0] key_onehot,
    output logic        key_ready,
    input  logic        start,
    input  logic [2:0]  opc_in,
    output logic [15:0] alu_inp1,
    output logic [15:0] alu_inp2,
    output logic [2:0]  alu_opc,
    input  logic [15:0] alu_out,
    input  logic        alu_ovf,
    output logic [15:0] res_onehot,
    output logic        res_ovf,
    output logic        res_valid,
    input  logic        res_ack,
    output logic        busy,
    output logic        err
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("onehot_alu_sequencer: SETTLE_CYCLES must be within 1..15");
    end

    localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        LOAD_A  = 3'd0,
        LOAD_B  = 3'd1,
        WAIT_OP = 3'd2,
        EXEC    = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t     state, state_d;
    logic [3:0] cnt, cnt_d;
    logic       err_d;
    logic       load_a, load_b, load_opc, capture, clear_valid, chain;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    function automatic logic is_onehot(input logic [15:0] v);
        return (v != 16'h0000) && ((v & (v - 16'h0001)) == 16'h0000);
    endfunction

    assign key_ready = (state == LOAD_A) || (state == LOAD_B);
    assign busy      = (state != LOAD_A);

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        err_d       = 1'b0;
        load_a      = 1'b0;
        load_b      = 1'b0;
        load_opc    = 1'b0;
        capture     = 1'b0;
        clear_valid = 1'b0;
        chain       = 1'b0;
        case (state)
            LOAD_A, LOAD_B: begin
                if (key_valid) begin
                    if (is_onehot(key_onehot)) begin
                        if (state == LOAD_A) begin
                            load_a  = 1'b1;
                            state_d = LOAD_B;
                        end else begin
                            load_b  = 1'b1;
                            state_d = WAIT_OP;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            WAIT_OP: begin
                if (start) begin
                    if (opc_in != 3'b000) begin
                        load_opc = 1'b1;
                        cnt_d    = 4'd0;
                        state_d  = EXEC;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            EXEC: begin
                if (cnt == LAST_CNT) begin
                    capture = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt + 4'd1;
                end
            end
            DONE: begin
                if (res_ack) begin
                    clear_valid = 1'b1;
                    state_d     = LOAD_A;
`ifdef CHAIN_OPERAND_EN
                    // Running total: the held result becomes operand A.
                    if (start && !key_valid) begin
                        if (is_onehot(res_onehot)) begin
                            chain   = 1'b1;
                            state_d = LOAD_B;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
`endif
                end
            end
            default: state_d = LOAD_A;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= LOAD_A;
            cnt        <= 4'd0;
            err        <= 1'b0;
            alu_inp1   <= 16'h0001;
            alu_inp2   <= 16'h0001;
            alu_opc    <= 3'b000;
            res_onehot <= 16'h0000;
            res_ovf    <= 1'b0;
            res_valid  <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            err   <= err_d;
            if (load_a)
                alu_inp1 <= key_onehot;
            else if (chain)
                alu_inp1 <= res_onehot;
            if (load_b)
                alu_inp2 <= key_onehot;
            if (load_opc)
                alu_opc <= opc_in;
            if (capture) begin
                res_onehot <= alu_out;
                res_ovf    <= alu_ovf;
                res_valid  <= 1'b1;
            end else if (clear_valid) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_onehot_alu_sequencer.sv
// tb/tb_onehot_alu_sequencer.sv - directed self-checking bench for onehot_alu_sequencer
module tb_onehot_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_valid;
    logic [15:0] key_onehot;
    logic        key_ready;
    logic        start;
    logic [2:0]  opc_in;
    logic [15:0] alu_inp1, alu_inp2;
    logic [2:0]  alu_opc;
    logic [15:0] alu_out;
    logic        alu_ovf;
    logic [15:0] res_onehot;
    logic        res_ovf, res_valid, res_ack, busy, err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    onehot_alu_sequencer #(.SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .key_valid(key_valid), .key_onehot(key_onehot), .key_ready(key_ready),
        .start(start), .opc_in(opc_in),
        .alu_inp1(alu_inp1), .alu_inp2(alu_inp2), .alu_opc(alu_opc),
        .alu_out(alu_out), .alu_ovf(alu_ovf),
        .res_onehot(res_onehot), .res_ovf(res_ovf), .res_valid(res_valid),
        .res_ack(res_ack), .busy(busy), .err(err)
    );

    // Reference one-hot ALU: 001 = add mod 16 (ovf on carry), 010 = sub mod 16 (ovf on borrow).
    function automatic int dec(input logic [15:0] v);
        int r = 0;
        for (int i = 0; i < 16; i++)
            if (v[i]) r = i;
        return r;
    endfunction

    always_comb begin
        int a, b, s;
        a = dec(alu_inp1);
        b = dec(alu_inp2);
        alu_out = 16'h0001;
        alu_ovf = 1'b0;
        s = 0;
        if (alu_opc == 3'b001) begin
            s = a + b;
            alu_out = 16'h0001 << (s % 16);
            alu_ovf = (s > 15);
        end else if (alu_opc == 3'b010) begin
            s = a - b;
            alu_out = 16'h0001 << ((s + 16) % 16);
            alu_ovf = (s < 0);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_key(input logic [15:0] k);
        key_valid  = 1'b1;
        key_onehot = k;
        tick();
        key_valid  = 1'b0;
    endtask

    task automatic launch(input logic [2:0] op);
        start  = 1'b1;
        opc_in = op;
        tick();
        start  = 1'b0;
    endtask

    task automatic ack();
        res_ack = 1'b1;
        tick();
        res_ack = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; key_valid = 1'b0; key_onehot = 16'h0000;
        start = 1'b0; opc_in = 3'b000; res_ack = 1'b0;
        tick(); tick();
        check("rst_ready", key_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_valid", res_valid, 0);
        check("rst_err", err, 0);
        check("rst_inp1", alu_inp1, 16'h0001);
        check("rst_inp2", alu_inp2, 16'h0001);
        check("rst_opc", alu_opc, 0);
        check("rst_res", res_onehot, 0);
        check("rst_ovf", res_ovf, 0);
        rst_n = 1'b1;
        tick();

        // 1: 3 + 5 = 8
        send_key(16'h0008);
        check("t1_inp1", alu_inp1, 16'h0008);
        check("t1_busy_b", busy, 1);
        send_key(16'h0020);
        check("t1_inp2", alu_inp2, 16'h0020);
        check("t1_ready_wait", key_ready, 0);
        launch(3'b001);
        check("t1_opc", alu_opc, 3'b001);
        check("t1_valid_e0", res_valid, 0);
        tick();
        check("t1_valid_e1", res_valid, 0);
        tick();
        check("t1_valid_e2", res_valid, 1);
        check("t1_res", res_onehot, 16'h0100);
        check("t1_ovf", res_ovf, 0);
        start = 1'b1; opc_in = 3'b001;    // ignored (no chaining in default build) / held
        tick();
        start = 1'b0;
        check("t1_hold", res_valid, 1);
        ack();
        check("t1_ack_valid", res_valid, 0);
        check("t1_ack_busy", busy, 0);
        check("t1_ack_ready", key_ready, 1);

        // 2: 9 + 8 = 17 -> 1 with overflow
        send_key(16'h0200);
        send_key(16'h0100);
        launch(3'b001);
        tick(); tick();
        check("t2_valid", res_valid, 1);
        check("t2_res", res_onehot, 16'h0002);
        check("t2_ovf", res_ovf, 1);
        ack();

        // 3: invalid keys rejected in LOAD_A
        send_key(16'h0011);
        check("t3_err1", err, 1);
        check("t3_busy1", busy, 0);
        check("t3_inp1_kept", alu_inp1, 16'h0200);
        send_key(16'h0000);
        check("t3_err2", err, 1);
        check("t3_ready", key_ready, 1);
        tick();
        check("t3_err_clear", err, 0);
        send_key(16'h0020);
        check("t3_inp1", alu_inp1, 16'h0020);
        check("t3_busy_b", busy, 1);
        send_key(16'h0002);
        launch(3'b001);
        tick(); tick();
        check("t3_res", res_onehot, 16'h0040);
        ack();

        // 4: opcode 000 rejected, then 5 - 3 = 2
        send_key(16'h0020);
        send_key(16'h0008);
        send_key(16'h0001);               // key in WAIT_OP: ignored, no err
        check("t4_key_ignored_err", err, 0);
        check("t4_key_ignored_inp1", alu_inp1, 16'h0020);
        launch(3'b000);
        check("t4_err_opc", err, 1);
        check("t4_still_wait", key_ready, 0);
        check("t4_opc_kept", alu_opc, 3'b001);
        tick();
        check("t4_no_exec", res_valid, 0);
        launch(3'b010);
        check("t4_opc", alu_opc, 3'b010);
        tick(); tick();
        check("t4_valid", res_valid, 1);
        check("t4_res", res_onehot, 16'h0004);
        check("t4_ovf", res_ovf, 0);
        ack();

        // 5: reset during EXEC
        send_key(16'h0008);
        send_key(16'h0020);
        launch(3'b001);
        tick();
        rst_n = 1'b0;
        #1;
        check("t5_valid", res_valid, 0);
        check("t5_busy", busy, 0);
        check("t5_inp1", alu_inp1, 16'h0001);
        check("t5_opc", alu_opc, 0);
        check("t5_res", res_onehot, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick(); tick();
        check("t5_never_valid", res_valid, 0);
        check("t5_ready", key_ready, 1);
        send_key(16'h0004);
        check("t5_resume", alu_inp1, 16'h0004);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // 6: chaining from DONE
        send_key(16'h0008);
        send_key(16'h0020);
        launch(3'b001);
        tick(); tick();
        check("t6_res", res_onehot, 16'h0100);
        res_ack = 1'b1; start = 1'b1;
        tick();
        res_ack = 1'b0; start = 1'b0;
        check("t6_valid_clr", res_valid, 0);
`ifdef CHAIN_OPERAND_EN
        check("t6_inp1_chain", alu_inp1, 16'h0100);
        check("t6_load_b", busy, 1);
        check("t6_ready", key_ready, 1);
        send_key(16'h0002);
        launch(3'b001);
        tick(); tick();
        check("t6_chain_res", res_onehot, 16'h0200);
        ack();
`else
        check("t6_inp1_kept", alu_inp1, 16'h0008);
        check("t6_load_a", busy, 0);
        check("t6_ready", key_ready, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
